// File: rtl/dmem_dbg_pkg.sv
// Shared types and constants for the data-memory debug master.
//   state_e          : debug master FSM states
//   CMD_* / SIZE_*   : opcode field encodings
//   RESP_*           : single-byte response codes
//   MASK_*           : low three bits of data_mem_sign_mask per access size
package dmem_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_GRANT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [1:0] CMD_PING     = 2'b00;
    localparam logic [1:0] CMD_READ     = 2'b01;
    localparam logic [1:0] CMD_WRITE    = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL  = 2'b11;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [7:0] RESP_PING    = 8'h5A;
    localparam logic [7:0] RESP_WRITE   = 8'hA5;
    localparam logic [7:0] RESP_ERR     = 8'hEE;

    localparam logic [2:0] MASK_BYTE    = 3'b001;
    localparam logic [2:0] MASK_HALF    = 3'b011;
    localparam logic [2:0] MASK_WORD    = 3'b111;

    function automatic logic [2:0] size_to_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_to_mask = MASK_BYTE;
            SIZE_HALF: size_to_mask = MASK_HALF;
            SIZE_WORD: size_to_mask = MASK_WORD;
            default:   size_to_mask = 3'b000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = (addr_lo != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_shift_reg32.sv
// Assembles a little-endian 32-bit word from a stream of bytes: each
// shifted-in byte enters at the top, so after four shifts the first byte
// sits in [7:0].
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : take byte_in this cycle
//   byte_in    : incoming byte
//   word_next  : word as it will be after this edge (equals the held word
//                when shift_en is low), so the caller sees the full word on
//                the same edge that accepts the last byte
module byte_shift_reg32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        word_d = word_q;
        if (shift_en) begin
            word_d = {byte_in, word_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_next = word_d;

endmodule

// File: rtl/dmem_debug_master.sv
// Byte-stream debug initiator for the data-memory port. Parses ping / read /
// write frames from the rx stream, performs one memory access while holding
// halt, and returns response bytes on the tx stream.
//   rx_data/rx_valid/rx_ready : command byte stream in
//   tx_data/tx_valid/tx_ready : response byte stream out
//   halt                      : stall CPU, route memory port from here
//   data_mem_*                : memory port (addr, store data, strobes,
//                               sign_mask) and returned read data
import dmem_dbg_pkg::*;

module dmem_debug_master #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] data_mem_addr,
    output logic [31:0] data_mem_WrData,
    output logic        data_mem_memwrite,
    output logic        data_mem_memread,
    output logic [3:0]  data_mem_sign_mask,
    input  logic [31:0] data_mem_out
);

    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             mis_q, mis_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [23:0]      resp_buf_q, resp_buf_d;
    logic [1:0]       resp_left_q, resp_left_d;

    logic             rx_ready_q, rx_ready_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             halt_q, halt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wrdata_q, wrdata_d;
    logic [3:0]       mask_q, mask_d;
    logic             memwrite_q, memwrite_d;
    logic             memread_q, memread_d;

    logic             rx_fire, tx_fire;
    logic [31:0]      addr_word, data_word;
    logic             rsvd_unused;

    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready;

    // Opcode bits 5:3 carry no meaning.
    assign rsvd_unused = ^rx_data[5:3];

    byte_shift_reg32 u_addr_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  ((state_q == ST_ADDR) & rx_fire),
        .byte_in   (rx_data),
        .word_next (addr_word)
    );

    byte_shift_reg32 u_data_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  ((state_q == ST_WDATA) & rx_fire),
        .byte_in   (rx_data),
        .word_next (data_word)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        size_d      = size_q;
        uns_d       = uns_q;
        mis_d       = mis_q;
        lat_d       = lat_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        halt_d      = halt_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        mask_d      = mask_q;
        memwrite_d  = 1'b0;
        memread_d   = 1'b0;
        rx_ready_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cmd_d  = rx_data[7:6];
                    size_d = rx_data[1:0];
                    uns_d  = rx_data[2];
                    idx_d  = 2'd0;
                    if (rx_data[7:6] == CMD_ILLEGAL || rx_data[1:0] == SIZE_ILLEGAL) begin
                        state_d     = ST_RESP;
                        tx_valid_d  = 1'b1;
                        tx_data_d   = RESP_ERR;
                        resp_left_d = 2'd0;
                    end else if (rx_data[7:6] == CMD_PING) begin
                        state_d     = ST_RESP;
                        tx_valid_d  = 1'b1;
                        tx_data_d   = RESP_PING;
                        resp_left_d = 2'd0;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mis_d = misaligned(size_q, addr_word[1:0]);
                        if (cmd_q == CMD_WRITE) begin
                            state_d = ST_WDATA;
                        end else if (misaligned(size_q, addr_word[1:0])) begin
                            state_d     = ST_RESP;
                            tx_valid_d  = 1'b1;
                            tx_data_d   = RESP_ERR;
                            resp_left_d = 2'd0;
                        end else begin
                            state_d  = ST_GRANT;
                            halt_d   = 1'b1;
                            addr_d   = addr_word;
                            wrdata_d = '0;
                            mask_d   = {uns_q, size_to_mask(size_q)};
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (rx_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Alignment was judged when the address completed;
                        // the data bytes are still consumed before the error.
                        if (mis_q) begin
                            state_d     = ST_RESP;
                            tx_valid_d  = 1'b1;
                            tx_data_d   = RESP_ERR;
                            resp_left_d = 2'd0;
                        end else begin
                            state_d  = ST_GRANT;
                            halt_d   = 1'b1;
                            addr_d   = addr_word;
                            wrdata_d = data_word;
                            mask_d   = {uns_q, size_to_mask(size_q)};
                        end
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_ACCESS;
                lat_d   = '0;
                if (cmd_q == CMD_WRITE) begin
                    memwrite_d = 1'b1;
                end else begin
                    memread_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cmd_q == CMD_WRITE) begin
                    state_d     = ST_RESP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RESP_WRITE;
                    resp_left_d = 2'd0;
                end else if (lat_q == LAT_LAST) begin
                    state_d     = ST_RESP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = data_mem_out[7:0];
                    resp_buf_d  = data_mem_out[31:8];
                    resp_left_d = 2'd3;
                end else begin
                    lat_d     = lat_q + 1'b1;
                    memread_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    if (resp_left_q == 2'd0) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                    end else begin
                        tx_data_d   = resp_buf_q[7:0];
                        resp_buf_d  = {8'h00, resp_buf_q[23:8]};
                        resp_left_d = resp_left_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The memory port is only driven while an access owns it.
        if (state_d != ST_GRANT && state_d != ST_ACCESS) begin
            halt_d   = 1'b0;
            addr_d   = '0;
            wrdata_d = '0;
            mask_d   = '0;
        end

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cmd_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            mis_q       <= 1'b0;
            lat_q       <= '0;
            resp_buf_q  <= '0;
            resp_left_q <= '0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            halt_q      <= 1'b0;
            addr_q      <= '0;
            wrdata_q    <= '0;
            mask_q      <= '0;
            memwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            mis_q       <= mis_d;
            lat_q       <= lat_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            halt_q      <= halt_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            mask_q      <= mask_d;
            memwrite_q  <= memwrite_d;
            memread_q   <= memread_d;
        end
    end

    assign rx_ready           = rx_ready_q;
    assign tx_data            = tx_data_q;
    assign tx_valid           = tx_valid_q;
    assign halt               = halt_q;
    assign data_mem_addr      = addr_q;
    assign data_mem_WrData    = wrdata_q;
    assign data_mem_sign_mask = mask_q;
    assign data_mem_memwrite  = memwrite_q;
    assign data_mem_memread   = memread_q;

endmodule

// File: tb/tb_dmem_debug_master.sv
module tb_dmem_debug_master;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        halt;
    logic [31:0] data_mem_addr;
    logic [31:0] data_mem_WrData;
    logic        data_mem_memwrite;
    logic        data_mem_memread;
    logic [3:0]  data_mem_sign_mask;
    logic [31:0] data_mem_out = '0;

    dmem_debug_master #(.READ_LATENCY(RL)) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .halt               (halt),
        .data_mem_addr      (data_mem_addr),
        .data_mem_WrData    (data_mem_WrData),
        .data_mem_memwrite  (data_mem_memwrite),
        .data_mem_memread   (data_mem_memread),
        .data_mem_sign_mask (data_mem_sign_mask),
        .data_mem_out       (data_mem_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int e_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: strobe counts, first-strobe cycle relative to the last
    // accepted frame byte, and the bus values seen while halt is high.
    int          wr_cnt, rd_cnt, halt_cnt;
    int          first_wr_diff, first_rd_diff, first_halt_diff;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_mask;

    task automatic clear_mon();
        wr_cnt = 0; rd_cnt = 0; halt_cnt = 0;
        first_wr_diff = -1; first_rd_diff = -1; first_halt_diff = -1;
        cap_addr = '0; cap_wd = '0; cap_mask = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", 32'(data_mem_memwrite & data_mem_memread), 32'd0);
            if (!halt) begin
                chk("idle_bus_zero", 32'(data_mem_addr | data_mem_WrData | 32'(data_mem_sign_mask)), 32'd0);
                chk("strobe_without_halt", 32'(data_mem_memwrite | data_mem_memread), 32'd0);
            end else begin
                if (halt_cnt == 0) begin
                    first_halt_diff = cyc - e_cyc;
                    cap_addr = data_mem_addr;
                    cap_wd   = data_mem_WrData;
                    cap_mask = data_mem_sign_mask;
                end else begin
                    chk("addr_stable", data_mem_addr, cap_addr);
                    chk("wrdata_stable", data_mem_WrData, cap_wd);
                    chk("mask_stable", 32'(data_mem_sign_mask), 32'(cap_mask));
                end
                halt_cnt++;
            end
            if (data_mem_memwrite) begin
                if (wr_cnt == 0) first_wr_diff = cyc - e_cyc;
                wr_cnt++;
            end
            if (data_mem_memread) begin
                if (rd_cnt == 0) first_rd_diff = cyc - e_cyc;
                rd_cnt++;
            end
        end
    end

    // Memory: the true read value is only present in the last memread cycle,
    // so sampling on any other edge yields the complement.
    logic [31:0] rd_value = '0;
    int          rd_run = 0;
    always @(negedge clk) begin
        if (data_mem_memread) rd_run = rd_run + 1;
        else                  rd_run = 0;
        data_mem_out = (data_mem_memread && rd_run == RL) ? rd_value : ~rd_value;
    end

    // Reference model: from the frame contents, what the master must do.
    // kind: 0 no access, 1 read, 2 write. lat: negedges from last frame byte
    // to the first response byte, minus one.
    task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                         output int frame_len, output logic [7:0] resp[4], output int nresp,
                         output int kind, output logic [3:0] mask, output int lat);
        int cmd, size, align;
        cmd  = int'(op[7:6]);
        size = int'(op[1:0]);
        for (int i = 0; i < 4; i++) resp[i] = 8'h00;
        kind = 0; nresp = 1; lat = 0; mask = '0;
        if (cmd == 3 || size == 3) begin
            frame_len = 1; resp[0] = 8'hEE;
        end else if (cmd == 0) begin
            frame_len = 1; resp[0] = 8'h5A;
        end else begin
            frame_len = (cmd == 1) ? 5 : 9;
            align = 1 << size;
            mask = {op[2], 3'((1 << (size + 1)) - 1)};
            if ((addr % align) != 0) begin
                resp[0] = 8'hEE;
            end else if (cmd == 1) begin
                kind = 1; nresp = 4; lat = RL + 1;
                for (int i = 0; i < 4; i++) resp[i] = 8'((rdata >> (8 * i)) & 32'hFF);
            end else begin
                kind = 2; lat = 2; resp[0] = 8'hA5;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e_cyc    = cyc;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic expect_resp(input logic [7:0] exp[4], input int n, input int lat,
                               input int stall_at, input string tag);
        int w;
        logic [7:0] hold;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                w = 0;
                while (!tx_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                if (!tx_valid) begin
                    chk({tag, "_tx_timeout"}, 32'd0, 32'd1);
                    return;
                end
                chk({tag, "_latency"}, 32'(cyc - e_cyc), 32'(lat));
            end else begin
                chk({tag, "_tx_back_to_back"}, 32'(tx_valid), 32'd1);
            end
            if (i == stall_at) begin
                tx_ready = 1'b0;
                hold = tx_data;
                repeat (5) begin
                    @(negedge clk);
                    chk({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
                    chk({tag, "_stall_data"}, 32'(tx_data), 32'(hold));
                end
                tx_ready = 1'b1;
            end
            chk({tag, "_byte"}, 32'(tx_data), 32'(exp[i]));
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, "_tx_done"}, 32'(tx_valid), 32'd0);
        chk({tag, "_rx_ready_back"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int stall_at, input string tag);
        int frame_len, nresp, kind, lat;
        logic [7:0] resp[4];
        logic [3:0] mask;
        model(op, addr, rdata, frame_len, resp, nresp, kind, mask, lat);
        rd_value = rdata;
        clear_mon();
        send_byte(op);
        if (frame_len > 1)
            for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) & 32'hFF));
        if (frame_len > 5)
            for (int i = 0; i < 4; i++) send_byte(8'((wdata >> (8 * i)) & 32'hFF));
        expect_resp(resp, nresp, lat, stall_at, tag);
        if (kind == 0) begin
            chk({tag, "_no_halt"}, 32'(halt_cnt), 32'd0);
            chk({tag, "_no_strobe"}, 32'(wr_cnt + rd_cnt), 32'd0);
        end else begin
            chk({tag, "_halt_start"}, 32'(first_halt_diff), 32'd0);
            chk({tag, "_addr"}, cap_addr, addr);
            chk({tag, "_mask"}, 32'(cap_mask), 32'(mask));
            if (kind == 2) begin
                chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'd2);
                chk({tag, "_memwrite_cycles"}, 32'(wr_cnt), 32'd1);
                chk({tag, "_memwrite_start"}, 32'(first_wr_diff), 32'd1);
                chk({tag, "_memread_cycles"}, 32'(rd_cnt), 32'd0);
                chk({tag, "_wrdata"}, cap_wd, wdata);
            end else begin
                chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(RL + 1));
                chk({tag, "_memread_cycles"}, 32'(rd_cnt), 32'(RL));
                chk({tag, "_memread_start"}, 32'(first_rd_diff), 32'd1);
                chk({tag, "_memwrite_cycles"}, 32'(wr_cnt), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] a, wd, rd;
        int          w;

        // Reset state, before any clock edge.
        #3;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_strobes", 32'({data_mem_memwrite, data_mem_memread}), 32'd0);
        chk("rst_bus", data_mem_addr | data_mem_WrData | 32'(data_mem_sign_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(8'h00, 32'h0, 32'h0, 32'h0, -1, "ping");
        run_txn(8'h82, 32'h0000_0010, 32'h1234_5678, 32'h0, -1, "word_write");
        run_txn(8'h40, 32'h0000_0011, 32'h0, 32'hFFFF_FF80, -1, "sbyte_read");
        run_txn(8'h41, 32'h0000_0013, 32'h0, 32'h1111_2222, -1, "misaligned_half_read");
        run_txn(8'h82, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, -1, "misaligned_word_write");
        run_txn(8'hC0, 32'h0, 32'h0, 32'h0, -1, "illegal_cmd");
        run_txn(8'h00, 32'h0, 32'h0, 32'h0, -1, "ping_after_illegal");
        run_txn(8'h43, 32'h0, 32'h0, 32'h0, -1, "illegal_size");
        run_txn(8'h45, 32'h0000_0102, 32'h0, 32'h0000_BEEF, -1, "uhalf_read");
        run_txn(8'h42, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1, "backpressure_read");

        // Reset pulse during the ACCESS phase of a read.
        rd_value = 32'hA5A5_5A5A;
        clear_mon();
        send_byte(8'h42);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        w = 0;
        @(negedge clk);
        while (!data_mem_memread && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midreset_reached_access", 32'(data_mem_memread), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_memread_drop", 32'(data_mem_memread), 32'd0);
        chk("midreset_halt_drop", 32'(halt), 32'd0);
        chk("midreset_bus_drop", data_mem_addr | 32'(data_mem_sign_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(8'h00, 32'h0, 32'h0, 32'h0, -1, "ping_after_reset");

        // Randomized frames against the model.
        for (int t = 0; t < 40; t++) begin
            op[7:6] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            op[5:3] = 3'($urandom_range(0, 7));
            op[2]   = 1'($urandom_range(0, 1));
            op[1:0] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            rd = $urandom;
            run_txn(op, a, wd, rd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
